// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master controller and its datapath.
package i2c_pkg;

    // Default SCL quarter-period length in clk cycles (100 kHz at 50 MHz).
    localparam int I2C_CLK_DIV = 125;

    // Width of the byte-count request.
    localparam int I2C_NB_W = 5;

    // State codes shared with the datapath; 9..15 are illegal.
    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_START      = 4'd1,
        ST_ADDRESS    = 4'd2,
        ST_READ_ACK   = 4'd3,
        ST_WRITE      = 4'd4,
        ST_READ       = 4'd5,
        ST_READ_ACK_1 = 4'd6,
        ST_WRITE_ACK  = 4'd7,
        ST_STOP       = 4'd8
    } i2c_state_e;

    // True for states in which the datapath shifts an address/data byte.
    function automatic logic is_shift_state(input logic [3:0] st);
        return (st == ST_ADDRESS) || (st == ST_WRITE) || (st == ST_READ);
    endfunction

endpackage

// File: rtl/i2c_scl_gen.sv
// SCL timing generator: quarter-period divider, bit strobe and SCL-high
// midpoint pulse. Counters are held at zero while disabled so every
// transfer starts on a clean SCL period boundary.
module i2c_scl_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = I2C_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_scl_n,
    output logic o_smp,
    output logic o_scl_base
);

    localparam logic [9:0] DIV_MAX = 10'(CLK_DIV - 1);

    logic [9:0] r_div_cnt;
    logic [1:0] r_q;
    logic       w_div_wrap;

    assign w_div_wrap = (r_div_cnt == DIV_MAX);

    // Divider and quarter counter advance only while the controller is busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_q       <= '0;
        end else if (!i_en) begin
            r_div_cnt <= '0;
            r_q       <= '0;
        end else if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_q       <= r_q + 2'd1;
        end else begin
            r_div_cnt <= r_div_cnt + 10'd1;
        end
    end

    assign o_scl_n    = i_en && w_div_wrap && (r_q == 2'd3);
    assign o_smp      = i_en && w_div_wrap && (r_q == 2'd2);
    assign o_scl_base = r_q[1];

endmodule

// File: rtl/i2c_master_ctrl.sv
// I2C master control FSM: sequences START, address, data bytes, ACK slots
// and STOP around the datapath, and generates SCL timing.
//
// state         | meaning
// --------------+---------------------------------------------------------
// IDLE          | waiting for start; SCL released, timing counters held
// START         | START condition; datapath must accept within two strobes
// ADDRESS       | shifting the 7-bit address plus direction bit
// READ_ACK      | sampling slave ACK after the address byte
// WRITE         | shifting a write data byte
// READ          | shifting a read data byte
// READ_ACK_1    | sampling slave ACK after a write data byte
// WRITE_ACK     | master ACK/NACK slot after a read data byte
// STOP          | STOP condition; SCL released after first strobe
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = I2C_CLK_DIV,
    parameter int NB_W    = I2C_NB_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            rw_in,
    input  logic [NB_W-1:0] nbytes,
    input  logic            sda_in,
    input  logic            counter,
    input  logic            stop_done,
    input  logic            st_ena,
    output logic [3:0]      state,
    output logic            scl_n,
    output logic            scl_out,
    output logic            count_o_stop,
    output logic            last_byte,
    output logic            busy,
    output logic            done,
    output logic            ack_err
);

    i2c_state_e      r_state;
    logic            r_rw;
    logic [NB_W-1:0] r_rem;
    logic            r_ack;
    logic            r_ack_err;
    logic            r_st_seen;
    logic            r_start_wait;
    logic [1:0]      r_stop_cnt;

    i2c_state_e      w_state_nxt;
    logic            w_rw_nxt;
    logic [NB_W-1:0] w_rem_nxt;
    logic            w_ack_nxt;
    logic            w_ack_err_nxt;
    logic            w_st_seen_nxt;
    logic            w_start_wait_nxt;
    logic [1:0]      w_stop_cnt_nxt;

    logic            w_busy;
    logic            w_scl_n;
    logic            w_smp;
    logic            w_scl_base;

    assign w_busy = (r_state != ST_IDLE);

    i2c_scl_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_scl_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (w_busy),
        .o_scl_n    (w_scl_n),
        .o_smp      (w_smp),
        .o_scl_base (w_scl_base)
    );

    // State and transaction context registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_rw         <= 1'b0;
            r_rem        <= '0;
            r_ack        <= 1'b0;
            r_ack_err    <= 1'b0;
            r_st_seen    <= 1'b0;
            r_start_wait <= 1'b0;
            r_stop_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rw         <= w_rw_nxt;
            r_rem        <= w_rem_nxt;
            r_ack        <= w_ack_nxt;
            r_ack_err    <= w_ack_err_nxt;
            r_st_seen    <= w_st_seen_nxt;
            r_start_wait <= w_start_wait_nxt;
            r_stop_cnt   <= w_stop_cnt_nxt;
        end
    end

    // Next-state and pulse outputs; all moves except IDLE->START wait for
    // the bit strobe. A NACK is tested before the remaining-byte count.
    always_comb begin
        w_state_nxt      = r_state;
        w_rw_nxt         = r_rw;
        w_rem_nxt        = r_rem;
        w_ack_nxt        = r_ack;
        w_ack_err_nxt    = r_ack_err;
        w_st_seen_nxt    = r_st_seen;
        w_start_wait_nxt = r_start_wait;
        w_stop_cnt_nxt   = r_stop_cnt;
        done             = 1'b0;
        count_o_stop     = 1'b0;
        last_byte        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_rw_nxt         = rw_in;
                    w_rem_nxt        = nbytes;
                    w_ack_nxt        = 1'b0;
                    w_ack_err_nxt    = 1'b0;
                    w_st_seen_nxt    = 1'b0;
                    w_start_wait_nxt = 1'b0;
                    w_stop_cnt_nxt   = '0;
                    w_state_nxt      = ST_START;
                end
            end

            ST_START: begin
                if (st_ena) begin
                    w_st_seen_nxt = 1'b1;
                end
                if (w_scl_n) begin
                    if (r_st_seen || st_ena) begin
                        w_state_nxt = ST_ADDRESS;
                    end else if (r_start_wait) begin
                        w_ack_err_nxt = 1'b1;
                        w_state_nxt   = ST_STOP;
                    end else begin
                        w_start_wait_nxt = 1'b1;
                    end
                end
            end

            ST_ADDRESS: begin
                if (w_scl_n && counter) begin
                    w_state_nxt = ST_READ_ACK;
                end
            end

            ST_READ_ACK: begin
                if (w_smp) begin
                    w_ack_nxt = sda_in;
                end
                if (w_scl_n) begin
                    if (r_ack) begin
                        w_ack_err_nxt = 1'b1;
                        w_state_nxt   = ST_STOP;
                    end else if (r_rem == '0) begin
                        w_state_nxt = ST_STOP;
                    end else if (!r_rw) begin
                        w_state_nxt = ST_WRITE;
                    end else begin
                        w_state_nxt = ST_READ;
                    end
                end
            end

            ST_WRITE: begin
                if (w_scl_n && counter) begin
                    w_state_nxt = ST_READ_ACK_1;
                end
            end

            ST_READ_ACK_1: begin
                if (w_smp) begin
                    w_ack_nxt = sda_in;
                end
                if (w_scl_n) begin
                    if (r_ack) begin
                        w_ack_err_nxt = 1'b1;
                        w_state_nxt   = ST_STOP;
                    end else begin
                        w_rem_nxt   = r_rem - 1'b1;
                        w_state_nxt = (r_rem == NB_W'(1)) ? ST_STOP : ST_WRITE;
                    end
                end
            end

            ST_READ: begin
                if (w_scl_n && counter) begin
                    w_state_nxt = ST_WRITE_ACK;
                end
            end

            ST_WRITE_ACK: begin
                last_byte = (r_rem == NB_W'(1));
                if (w_scl_n) begin
                    w_rem_nxt   = r_rem - 1'b1;
                    w_state_nxt = (r_rem == NB_W'(1)) ? ST_STOP : ST_READ;
                end
            end

            ST_STOP: begin
                if (w_scl_n) begin
                    if (stop_done || (r_stop_cnt == 2'd3)) begin
                        if (!stop_done) begin
                            w_ack_err_nxt = 1'b1;
                        end
                        done         = 1'b1;
                        count_o_stop = 1'b1;
                        w_state_nxt  = ST_IDLE;
                    end else begin
                        w_stop_cnt_nxt = r_stop_cnt + 2'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign state   = r_state;
    assign scl_n   = w_scl_n;
    assign busy    = w_busy;
    assign ack_err = r_ack_err;
    assign scl_out = (r_state == ST_IDLE) ? 1'b1 :
                     ((r_state == ST_STOP) && (r_stop_cnt != 2'd0)) ? 1'b1 :
                     w_scl_base;

endmodule
